ram_refill_unit: RTL and testbench

Sits between the data cache in the memory stage and the word-wide main RAM. It serves the cache's 128-bit line-fill requests on a miss by issuing four sequential 32-bit RAM reads and assembling them into one line. It also forwards single-word write-through stores from the cache to RAM. It is the block that produces the cache's line-fill data input, directly upstream of the memory stage.

---
 rtl/ram_refill_unit.sv | 137 +++++++++++++
 tb/tb_ram_refill_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_refill_unit.sv
// Data-cache refill and write-through engine: serves 4-beat line fills and
// single-word stores against a word-wide RAM with a req/ack handshake.
module ram_refill_unit (
  input  logic         clk,
  input  logic         rstn,
  input  logic         imiss,
  input  logic [31:0]  imiss_addr,
  input  logic         iwrite_req,
  input  logic [31:0]  iwrite_addr,
  input  logic [31:0]  iwrite_data,
  output logic [127:0] oline,
  output logic         oline_valid,
  output logic         owrite_done,
  output logic         obusy,
  output logic         oram_req,
  output logic         oram_we,
  output logic [31:0]  oram_addr,
  output logic [31:0]  oram_wdata,
  input  logic         iram_ack,
  input  logic [31:0]  iram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [127:0]   oline_q, oline_d;
  logic           oline_valid_q, oline_valid_d;
  logic           owrite_done_q, owrite_done_d;
  logic           obusy_q, obusy_d;
  logic           oram_req_q, oram_req_d;
  logic           oram_we_q, oram_we_d;
  logic [31:0]    oram_addr_q, oram_addr_d;
  logic [31:0]    oram_wdata_q, oram_wdata_d;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    oline_d       = oline_q;
    oline_valid_d = 1'b0;
    owrite_done_d = 1'b0;
    oram_req_d    = oram_req_q;
    oram_we_d     = oram_we_q;
    oram_addr_d   = oram_addr_q;
    oram_wdata_d  = oram_wdata_q;

    case (state_q)
      S_IDLE: begin
        // Store has priority so RAM is updated before any refill reads it.
        if (iwrite_req) begin
          state_d      = S_WRITE;
          oram_req_d   = 1'b1;
          oram_we_d    = 1'b1;
          oram_addr_d  = iwrite_addr;
          oram_wdata_d = iwrite_data;
        end else if (imiss) begin
          state_d     = S_READ;
          beat_d      = 2'd0;
          oram_req_d  = 1'b1;
          oram_we_d   = 1'b0;
          oram_addr_d = imiss_addr & 32'hFFFF_FFF0;
        end
      end
      S_WRITE: begin
        if (iram_ack) begin
          state_d       = S_IDLE;
          oram_req_d    = 1'b0;
          oram_we_d     = 1'b0;
          owrite_done_d = 1'b1;
        end
      end
      S_READ: begin
        if (iram_ack) begin
          oline_d[{beat_q, 5'd0} +: 32] = iram_rdata;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d       = S_DONE;
            oram_req_d    = 1'b0;
            oline_valid_d = 1'b1;
          end else begin
            // Address register doubles as base + 4*beat.
            oram_addr_d = oram_addr_q + 32'd4;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    obusy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      oline_q       <= '0;
      oline_valid_q <= 1'b0;
      owrite_done_q <= 1'b0;
      obusy_q       <= 1'b0;
      oram_req_q    <= 1'b0;
      oram_we_q     <= 1'b0;
      oram_addr_q   <= '0;
      oram_wdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      oline_q       <= oline_d;
      oline_valid_q <= oline_valid_d;
      owrite_done_q <= owrite_done_d;
      obusy_q       <= obusy_d;
      oram_req_q    <= oram_req_d;
      oram_we_q     <= oram_we_d;
      oram_addr_q   <= oram_addr_d;
      oram_wdata_q  <= oram_wdata_d;
    end
  end

  assign oline       = oline_q;
  assign oline_valid = oline_valid_q;
  assign owrite_done = owrite_done_q;
  assign obusy       = obusy_q;
  assign oram_req    = oram_req_q;
  assign oram_we     = oram_we_q;
  assign oram_addr   = oram_addr_q;
  assign oram_wdata  = oram_wdata_q;

endmodule

// File: tb/tb_ram_refill_unit.sv
// Directed bench for ram_refill_unit: RAM model with programmable wait states,
// negedge monitor logging accepted beats, line pulses and write completions.
module tb_ram_refill_unit;

  logic         clk = 1'b0;
  logic         rstn;
  logic         imiss;
  logic [31:0]  imiss_addr;
  logic         iwrite_req;
  logic [31:0]  iwrite_addr;
  logic [31:0]  iwrite_data;
  logic [127:0] oline;
  logic         oline_valid;
  logic         owrite_done;
  logic         obusy;
  logic         oram_req;
  logic         oram_we;
  logic [31:0]  oram_addr;
  logic [31:0]  oram_wdata;
  logic         iram_ack;
  logic [31:0]  iram_rdata;

  ram_refill_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .imiss       (imiss),
    .imiss_addr  (imiss_addr),
    .iwrite_req  (iwrite_req),
    .iwrite_addr (iwrite_addr),
    .iwrite_data (iwrite_data),
    .oline       (oline),
    .oline_valid (oline_valid),
    .owrite_done (owrite_done),
    .obusy       (obusy),
    .oram_req    (oram_req),
    .oram_we     (oram_we),
    .oram_addr   (oram_addr),
    .oram_wdata  (oram_wdata),
    .iram_ack    (iram_ack),
    .iram_rdata  (iram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
  } beat_t;

  int           tests  = 0;
  int           failed = 0;
  int           cyc    = 0;
  int           wait_cfg = 0;
  int           wait_cnt = 0;
  logic         spur   = 1'b0;
  int           busy_cnt = 0;
  int           stable_err = 0;
  logic         hold_pend = 1'b0;
  logic [31:0]  hold_addr = '0;
  logic [31:0]  mem [logic [31:0]];
  beat_t        bq[$];
  int           vcyc[$];
  logic [127:0] vline[$];
  int           dq[$];
  int           t0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic beat_t getb(input int i);
    beat_t b;
    b = '{cyc: -1, addr: '0, we: 1'b0, wd: '0};
    if (i < bq.size()) b = bq[i];
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model and monitor; ack decided here takes effect at the next posedge.
  always @(negedge clk) begin
    if (oram_req && hold_pend && (oram_addr !== hold_addr)) stable_err++;
    if (obusy) busy_cnt++;
    if (oram_req) begin
      if (wait_cnt < wait_cfg) begin
        iram_ack = 1'b0;
        wait_cnt++;
      end else begin
        iram_ack = 1'b1;
        wait_cnt = 0;
        if (oram_we) mem[oram_addr] = oram_wdata;
        else iram_rdata = mem.exists(oram_addr) ? mem[oram_addr] : oram_addr;
        bq.push_back('{cyc: cyc, addr: oram_addr, we: oram_we, wd: oram_wdata});
      end
    end else begin
      iram_ack   = spur;
      iram_rdata = 32'h5A5A_5A5A;
    end
    hold_pend = oram_req && !iram_ack;
    hold_addr = oram_addr;
    if (oline_valid) begin
      vcyc.push_back(cyc);
      vline.push_back(oline);
    end
    if (owrite_done) dq.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bq.delete();
    vcyc.delete();
    vline.delete();
    dq.delete();
    busy_cnt   = 0;
    stable_err = 0;
  endtask

  task automatic start_miss(input logic [31:0] a);
    step();
    imiss      = 1'b1;
    imiss_addr = a;
    t0         = cyc;
    step();
    imiss      = 1'b0;
  endtask

  task automatic check_refill(input string tag, input logic [31:0] base, input int stride,
                              input int first, input int vexp);
    beat_t b;
    chk({tag, "_nbeats"}, 128'(bq.size()), 128'(4));
    for (int i = 0; i < 4; i++) begin
      b = getb(i);
      chk({tag, "_addr"}, 128'(b.addr), 128'(base + 32'(4 * i)));
      chk({tag, "_bcyc"}, 128'(b.cyc), 128'(first + stride * i));
    end
    chk({tag, "_nvalid"}, 128'(vcyc.size()), 128'(1));
    if (vcyc.size() > 0) chk({tag, "_vcyc"}, 128'(vcyc[0]), 128'(vexp));
  endtask

  initial begin
    rstn = 1'b0; imiss = 1'b0; imiss_addr = '0;
    iwrite_req = 1'b0; iwrite_addr = '0; iwrite_data = '0;
    iram_ack = 1'b0; iram_rdata = '0;

    // Reset, then idle
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_oline", oline, '0);
    chk("rst_outs", {124'(0), oline_valid, owrite_done, obusy, oram_we}, '0);
    chk("rst_addr", 128'(oram_addr), '0);
    chk("rst_wdata", 128'(oram_wdata), '0);
    clear();
    repeat (3) @(negedge clk);
    chk("rst_noreq", 128'(bq.size() + int'(oram_req)), '0);

    // Spurious ack while idle is ignored
    clear();
    step(); spur = 1'b1;
    repeat (4) step();
    spur = 1'b0;
    chk("spur_nobeat", 128'(bq.size()), '0);
    chk("spur_idle", {126'(0), oram_req, obusy}, '0);

    // Zero-wait refill
    clear();
    start_miss(32'h0000_1234);
    repeat (8) step();
    check_refill("zw", 32'h0000_1230, 1, t0 + 1, t0 + 5);
    if (vline.size() > 0)
      chk("zw_line", vline[0], {32'h0000_123C, 32'h0000_1238, 32'h0000_1234, 32'h0000_1230});
    chk("zw_busy", 128'(busy_cnt), 128'(5));
    chk("zw_hold", oline, {32'h0000_123C, 32'h0000_1238, 32'h0000_1234, 32'h0000_1230});

    // Wait states: two idle cycles before each beat
    clear();
    wait_cfg = 2;
    start_miss(32'h0000_1234);
    repeat (16) step();
    check_refill("ws", 32'h0000_1230, 3, t0 + 3, t0 + 13);
    chk("ws_stable", 128'(stable_err), '0);
    wait_cfg = 0;

    // Plain write-through
    clear();
    step();
    iwrite_req = 1'b1; iwrite_addr = 32'h0000_1000; iwrite_data = 32'hCAFE_F00D;
    t0 = cyc;
    step();
    iwrite_req = 1'b0;
    repeat (4) step();
    chk("wr_nbeat", 128'(bq.size()), 128'(1));
    chk("wr_beat", {getb(0).we, getb(0).addr, getb(0).wd}, {1'b1, 32'h0000_1000, 32'hCAFE_F00D});
    chk("wr_bcyc", 128'(getb(0).cyc), 128'(t0 + 1));
    chk("wr_ndone", 128'(dq.size()), 128'(1));
    if (dq.size() > 0) chk("wr_dcyc", 128'(dq[0]), 128'(t0 + 2));
    chk("wr_busy", 128'(busy_cnt), 128'(1));

    // Simultaneous write and miss: write first, then refill sees the new word
    clear();
    step();
    iwrite_req = 1'b1; iwrite_addr = 32'h0000_1238; iwrite_data = 32'hDEAD_BEEF;
    imiss = 1'b1; imiss_addr = 32'h0000_1230;
    t0 = cyc;
    step();
    iwrite_req = 1'b0;
    step();
    step();
    imiss = 1'b0;
    repeat (8) step();
    chk("sim_nbeat", 128'(bq.size()), 128'(5));
    chk("sim_wr", {getb(0).we, getb(0).addr, getb(0).wd}, {1'b1, 32'h0000_1238, 32'hDEAD_BEEF});
    chk("sim_wcyc", 128'(getb(0).cyc), 128'(t0 + 1));
    if (dq.size() > 0) chk("sim_dcyc", 128'(dq[0]), 128'(t0 + 2));
    else chk("sim_ndone", 128'(dq.size()), 128'(1));
    chk("sim_rd0", {getb(1).we, getb(1).addr}, {1'b0, 32'h0000_1230});
    chk("sim_rcyc", 128'(getb(1).cyc), 128'(t0 + 3));
    chk("sim_nvalid", 128'(vcyc.size()), 128'(1));
    if (vline.size() > 0) begin
      chk("sim_vcyc", 128'(vcyc[0]), 128'(t0 + 7));
      chk("sim_line", vline[0], {32'h0000_123C, 32'hDEAD_BEEF, 32'h0000_1234, 32'h0000_1230});
    end

    // Reset after beat 1 is acked
    clear();
    start_miss(32'h0000_3000);
    step();
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk("mr_req", {126'(0), oram_req, obusy}, '0);
    repeat (6) step();
    chk("mr_novalid", 128'(vcyc.size()), '0);
    chk("mr_oline", oline, '0);

    clear();
    start_miss(32'h0000_2000);
    repeat (8) step();
    check_refill("mr2", 32'h0000_2000, 1, t0 + 1, t0 + 5);
    if (vline.size() > 0)
      chk("mr2_line", vline[0], {32'h0000_200C, 32'h0000_2008, 32'h0000_2004, 32'h0000_2000});

    // Top of memory: no wrap inside the line
    clear();
    start_miss(32'hFFFF_FFF8);
    repeat (8) step();
    check_refill("top", 32'hFFFF_FFF0, 1, t0 + 1, t0 + 5);
    if (vline.size() > 0)
      chk("top_line", vline[0], {32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF4, 32'hFFFF_FFF0});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
